image_gray_engine: RTL and testbench
====================================

IMAGE_GRAY_ENGINE -- requirements
Module: image_gray_engine

Interface
REQ-001 Parameter: ADDR_W, 6, row/col address width; image is 2^ADDR_W x 2^ADDR_W pixels.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  one-cycle request to process the whole image; sampled only in IDLE.
REQ-005 busy  output  1  high from the cycle after accepted start until DONE is left.
REQ-006 done  output  1  single-cycle pulse when the last pixel write has completed.
REQ-007 row  output  ADDR_W  image memory row address.
REQ-008 col  output  ADDR_W  image memory column address.
REQ-009 we  output  1  image memory write enable; write occurs at the rising edge while high.
REQ-010 pix_wr  output  24  pixel written to memory, {R[23:16],G[15:8],B[7:0]}.
REQ-011 pix_rd  input  24  pixel at (row,col), combinational read from memory.

Function
REQ-012 FSM states SHALL be IDLE, MIR_RA, MIR_RB, MIR_WA, MIR_WB, GRY_RD, GRY_WR, DONE; all outputs driven from registers.
REQ-013 IDLE: start=1 -> MIR_RA (mirror enabled) or GRY_RD (mirror disabled), row=col=0; start=0 -> stay.
REQ-014 start while busy SHALL be ignored; it is neither queued nor restarts processing.
REQ-015 Gray pass: GRY_RD drives (row,col) with we=0 and captures pix_rd at the clock edge; GRY_WR drives the same address with we=1 and pix_wr=gray(captured): 2 cycles per pixel.
REQ-016 gray(p): R=0, B=0, G=(max(R,G,B)+min(R,G,B))>>1, computed with a 9-bit sum, with no overflow and truncation toward zero.
REQ-017 Scan order SHALL be row-major, col fastest; col wraps 2^ADDR_W-1 -> 0 and increments row; GRY_WR at (max,max) -> DONE.
REQ-018 DONE: done=1 and busy=0 for exactly one cycle, then IDLE; start in DONE is ignored.
REQ-019 we SHALL be 1 only in GRY_WR, MIR_WA and MIR_WB.
REQ-020 Gray-pass latency SHALL be 2*4^ADDR_W cycles from the first GRY_RD to DONE (8192 at ADDR_W=6).

Reset
REQ-021 rst_n=0 SHALL asynchronously force IDLE, row=0, col=0, we=0, pix_wr=0, busy=0, done=0, and clear the capture registers.
REQ-022 Reset mid-operation SHALL abort immediately with we deasserted; the image is left partially processed; no done pulse.

Configuration
REQ-023 Macro IMG_MIRROR_EN defined: a vertical mirror pass precedes the gray pass; when undefined, the MIR_* states and the B capture register are not compiled, and start goes directly to GRY_RD.
REQ-024 Mirror pass: for r in 0..2^(ADDR_W-1)-1 and every col: MIR_RA reads (r,col) into regA; MIR_RB reads (max-r,col) into regB; MIR_WA writes regB to (r,col); MIR_WB writes regA to (max-r,col); 4 cycles per pair.
REQ-025 After MIR_WB at r=2^(ADDR_W-1)-1, col=max -> GRY_RD with row=col=0; mirror pass takes 2*4^ADDR_W cycles (total 16384 at ADDR_W=6).

Structure
REQ-026 Package image_pkg SHALL hold PIX_W=24, channel bit-range constants (R_HI/R_LO, G_HI/G_LO, B_HI/B_LO), and the FSM state enum.
REQ-027 The combinational gray(p) function SHALL be the sub-module gray_px (24-bit in, 24-bit out); the FSM, counters and capture registers stay in image_gray_engine.

Verification (memory model preloaded with pixel(i,j)=i+j, ADDR_W=6)
REQ-028 Mirror off, start pulse -> after 8192 cycles done pulses once; pixel(63,63)=0x003F00, pixel(0,1)=0x000000, pixel(10,20)=0x000F00.
REQ-029 IMG_MIRROR_EN defined, start -> done at cycle 16384; pixel(0,5)=0x002200 (from 68); pixel(63,0)=0x000000.
REQ-030 Memory preloaded with 0xFF8001 at (0,0) -> pixel(0,0)=0x008000 ((255+1)>>1=128, 9-bit sum without overflow).
REQ-031 start held high for 20 cycles during busy -> exactly one done pulse; the image is processed once.
REQ-032 rst_n low at cycle 100 -> we=0 asynchronously; busy=0; no done; a new start then reprocesses from (0,0).
REQ-033 Assertions: we=1 only in write states; col wrap increments row; done high for exactly one cycle per accepted start.

Source files
------------

// File: rtl/image_pkg.sv
// Pixel layout constants and FSM state encoding for image_gray_engine.
// The MIR_* states exist only when IMG_MIRROR_EN is defined.
package image_pkg;

  localparam int PIX_W = 24;
  localparam int R_HI  = 23;
  localparam int R_LO  = 16;
  localparam int G_HI  = 15;
  localparam int G_LO  = 8;
  localparam int B_HI  = 7;
  localparam int B_LO  = 0;

  typedef enum logic [2:0] {
`ifdef IMG_MIRROR_EN
    MIR_RA = 3'd4,
    MIR_RB = 3'd5,
    MIR_WA = 3'd6,
    MIR_WB = 3'd7,
`endif
    IDLE   = 3'd0,
    GRY_RD = 3'd1,
    GRY_WR = 3'd2,
    DONE   = 3'd3
  } state_t;

endpackage

// File: rtl/gray_px.sv
// Combinational gray conversion: G = (max + min) >> 1 over R,G,B with a
// 9-bit sum; R and B of the result are zero.
module gray_px
  import image_pkg::*;
(
  input  logic [PIX_W-1:0] pix,
  output logic [PIX_W-1:0] gray
);

  logic [7:0] r_s, g_s, b_s, max_rg_s, min_rg_s, max_s, min_s;
  logic [8:0] sum_s;

  // Channel extraction, extremes and midpoint
  always_comb begin
    r_s      = pix[R_HI:R_LO];
    g_s      = pix[G_HI:G_LO];
    b_s      = pix[B_HI:B_LO];
    max_rg_s = (r_s > g_s) ? r_s : g_s;
    min_rg_s = (r_s < g_s) ? r_s : g_s;
    max_s    = (max_rg_s > b_s) ? max_rg_s : b_s;
    min_s    = (min_rg_s < b_s) ? min_rg_s : b_s;
    sum_s    = {1'b0, max_s} + {1'b0, min_s};
    gray     = {PIX_W{1'b0}};
    gray[G_HI:G_LO] = sum_s[8:1];
  end

endmodule

// File: rtl/image_gray_engine_chk.sv
// Protocol checker for image_gray_engine: write enable only in write states,
// column wrap advances the row, done is a single-cycle pulse after the last write.
module image_gray_engine_chk
  import image_pkg::*;
#(
  parameter int ADDR_W = 6
)(
  input logic              clk,
  input logic              rst_n,
  input state_t            state,
  input logic              we,
  input logic              done,
  input logic [ADDR_W-1:0] row,
  input logic [ADDR_W-1:0] col
);

  localparam logic [ADDR_W-1:0] MAX_A = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic wr_state_s;
`ifdef IMG_MIRROR_EN
  assign wr_state_s = (state == GRY_WR) || (state == MIR_WA) || (state == MIR_WB);
`else
  assign wr_state_s = (state == GRY_WR);
`endif

  a_we_in_write: assert property (@(posedge clk) disable iff (!rst_n)
    we |-> wr_state_s);

  a_col_wrap: assert property (@(posedge clk) disable iff (!rst_n)
    (state == GRY_WR && col == MAX_A && row != MAX_A) |=>
      (col == {ADDR_W{1'b0}} && row == $past(row) + ONE_A));

  a_done_pulse: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

  a_done_after_last: assert property (@(posedge clk) disable iff (!rst_n)
    $rose(done) |-> $past(state == GRY_WR && row == MAX_A && col == MAX_A));

endmodule

// File: rtl/image_gray_engine.sv
// Whole-image gray conversion engine driving an external pixel memory.
// Define IMG_MIRROR_EN to prepend a vertical mirror pass.
module image_gray_engine
  import image_pkg::*;
#(
  parameter int ADDR_W = 6
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              we,
  output logic [PIX_W-1:0]  pix_wr,
  input  logic [PIX_W-1:0]  pix_rd
);

  localparam logic [ADDR_W-1:0] MAX_A = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ONE_A = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] row_r, row_s, col_r, col_s;
  logic              we_r, busy_r, done_r, last_col_s;
  logic [PIX_W-1:0]  cap_a_r, gray_s, pix_wr_s;
`ifdef IMG_MIRROR_EN
  localparam logic [ADDR_W-1:0] HALF_LAST = {1'b0, {(ADDR_W-1){1'b1}}};
  logic [PIX_W-1:0]  cap_b_r;
  logic [ADDR_W-1:0] mir_r_s;
  // In MIR_RB/MIR_WB row holds max-r, whose complement is the pair index r
  assign mir_r_s = ~row_r;
`endif

  function automatic logic is_write(input state_t s);
    case (s)
      GRY_WR:  return 1'b1;
`ifdef IMG_MIRROR_EN
      MIR_WA:  return 1'b1;
      MIR_WB:  return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  assign last_col_s = (col_r == MAX_A);

  gray_px u_gray (.pix(cap_a_r), .gray(gray_s));

  // Next state and next memory address
  always_comb begin
    state_s = state_r;
    row_s   = row_r;
    col_s   = col_r;
    case (state_r)
      IDLE: begin
        if (start) begin
`ifdef IMG_MIRROR_EN
          state_s = MIR_RA;
`else
          state_s = GRY_RD;
`endif
          row_s = {ADDR_W{1'b0}};
          col_s = {ADDR_W{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      GRY_RD: state_s = GRY_WR;
      GRY_WR: begin
        if (last_col_s && row_r == MAX_A) begin
          state_s = DONE;
        end else begin
          state_s = GRY_RD;
          col_s   = col_r + ONE_A;
          row_s   = last_col_s ? row_r + ONE_A : row_r;
        end
      end
      DONE: state_s = IDLE;
`ifdef IMG_MIRROR_EN
      MIR_RA: begin state_s = MIR_RB; row_s = ~row_r; end
      MIR_RB: begin state_s = MIR_WA; row_s = ~row_r; end
      MIR_WA: begin state_s = MIR_WB; row_s = ~row_r; end
      MIR_WB: begin
        if (last_col_s && mir_r_s == HALF_LAST) begin
          state_s = GRY_RD;
          row_s   = {ADDR_W{1'b0}};
          col_s   = {ADDR_W{1'b0}};
        end else begin
          state_s = MIR_RA;
          col_s   = col_r + ONE_A;
          row_s   = last_col_s ? mir_r_s + ONE_A : mir_r_s;
        end
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // Write data selected from the capture registers by the current write state
  always_comb begin
    pix_wr_s = {PIX_W{1'b0}};
    case (state_r)
      GRY_WR:  pix_wr_s = gray_s;
`ifdef IMG_MIRROR_EN
      MIR_WA:  pix_wr_s = cap_b_r;
      MIR_WB:  pix_wr_s = cap_a_r;
`endif
      default: pix_wr_s = {PIX_W{1'b0}};
    endcase
  end

  // State, address, control outputs and the primary capture register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      row_r   <= {ADDR_W{1'b0}};
      col_r   <= {ADDR_W{1'b0}};
      we_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      cap_a_r <= {PIX_W{1'b0}};
    end else begin
      state_r <= state_s;
      row_r   <= row_s;
      col_r   <= col_s;
      we_r    <= is_write(state_s);
      busy_r  <= (state_s != IDLE) && (state_s != DONE);
      done_r  <= (state_s == DONE);
`ifdef IMG_MIRROR_EN
      if (state_r == GRY_RD || state_r == MIR_RA) cap_a_r <= pix_rd;
      else cap_a_r <= cap_a_r;
`else
      if (state_r == GRY_RD) cap_a_r <= pix_rd;
      else cap_a_r <= cap_a_r;
`endif
    end
  end

`ifdef IMG_MIRROR_EN
  // Second capture register holds the partner-row pixel of a mirror pair
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cap_b_r <= {PIX_W{1'b0}};
    else if (state_r == MIR_RB) cap_b_r <= pix_rd;
    else cap_b_r <= cap_b_r;
  end
`endif

  assign row    = row_r;
  assign col    = col_r;
  assign we     = we_r;
  assign busy   = busy_r;
  assign done   = done_r;
  assign pix_wr = pix_wr_s;

  image_gray_engine_chk #(.ADDR_W(ADDR_W)) u_chk (
    .clk(clk), .rst_n(rst_n), .state(state_r), .we(we_r),
    .done(done_r), .row(row_r), .col(col_r)
  );

endmodule

// File: tb/tb_image_gray_engine.sv
// Self-checking bench for image_gray_engine with a 64x64 pixel memory model.
module tb_image_gray_engine;
  import image_pkg::*;

  localparam int AW = 6;
  localparam int N  = 64;
`ifdef IMG_MIRROR_EN
  localparam bit MIR = 1'b1;
`else
  localparam bit MIR = 1'b0;
`endif
  localparam int LAT = MIR ? 16384 : 8192;

  typedef struct { logic [23:0] pin; logic [23:0] pexp; } vec_t;
  typedef struct { int r; int c; logic [23:0] pexp; } spot_t;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, load_req = 1'b0;
  logic busy, done, we;
  logic [AW-1:0] row, col;
  logic [23:0] pix_wr, pix_rd;
  logic [23:0] mem      [N][N];
  logic [23:0] init_img [N][N];
  logic [23:0] exp_img  [N][N];
  int errors = 0, checks = 0, done_cnt = 0;
  vec_t  vt[9];
  spot_t sp[3];
  int    n_sp;

  always #5 clk = ~clk;

  image_gray_engine #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .row(row), .col(col), .we(we), .pix_wr(pix_wr), .pix_rd(pix_rd)
  );

  assign pix_rd = mem[row][col];

  always @(posedge clk) begin
    if (load_req) mem <= init_img;
    else if (we) mem[row][col] <= pix_wr;
  end

  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [23:0] gray_ref(input logic [23:0] p);
    int r, g, b, mx, mn;
    r = p[23:16]; g = p[15:8]; b = p[7:0];
    mx = r; mn = r;
    if (g > mx) mx = g;
    if (b > mx) mx = b;
    if (g < mn) mn = g;
    if (b < mn) mn = b;
    return {8'h00, 8'((mx + mn) / 2), 8'h00};
  endfunction

  task automatic load_and_model();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        exp_img[i][j] = gray_ref(init_img[MIR ? N - 1 - i : i][j]);
    @(negedge clk); load_req = 1'b1;
    @(negedge clk); load_req = 1'b0;
  endtask

  task automatic fill_diag();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        init_img[i][j] = 24'(i + j);
  endtask

  task automatic check_image(input string tag);
    int bad, bj;
    for (int i = 0; i < N; i++) begin
      bad = 0; bj = 0;
      for (int j = 0; j < N; j++)
        if (mem[i][j] !== exp_img[i][j]) begin
          if (bad == 0) bj = j;
          bad++;
        end
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s row %0d: %0d bad pixels, col %0d got %06h expected %06h",
                 tag, i, bad, bj, mem[i][bj], exp_img[i][bj]);
      end
    end
  endtask

  // start asserted for 'hold' cycles; checks acceptance, latency and the done pulse
  task automatic run_pass(input int hold);
    int c, d0;
    bit seen;
    @(negedge clk); start = 1'b1; d0 = done_cnt;
    @(posedge clk); #1;
    if (hold <= 1) start = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_row", 32'(row), 32'd0);
    chk("accept_col", 32'(col), 32'd0);
    chk("accept_we", 32'(we), 32'd0);
    c = 0; seen = 1'b0;
    while (!seen && c < LAT + 64) begin
      @(posedge clk); #1; c++;
      if (c >= hold) start = 1'b0;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(c), 32'(LAT));
    chk("done_busy", 32'(busy), 32'd0);
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("done_width", 32'(done), 32'd0);
    chk("start_in_done_ignored", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("idle_after_done", 32'(busy), 32'd0);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int vr, c;
    vt[0] = '{24'hFF8001, 24'h008000};
    vt[1] = '{24'hFFFFFF, 24'h00FF00};
    vt[2] = '{24'h000000, 24'h000000};
    vt[3] = '{24'h010203, 24'h000200};
    vt[4] = '{24'h0A0B0C, 24'h000B00};
    vt[5] = '{24'hFF0000, 24'h007F00};
    vt[6] = '{24'h00FF00, 24'h007F00};
    vt[7] = '{24'h123456, 24'h003400};
    vt[8] = '{24'h80FE01, 24'h007F00};
`ifdef IMG_MIRROR_EN
    sp[0] = '{0, 5, 24'h002200};
    sp[1] = '{63, 0, 24'h000000};
    n_sp = 2;
`else
    sp[0] = '{63, 63, 24'h003F00};
    sp[1] = '{0, 1, 24'h000000};
    sp[2] = '{10, 20, 24'h000F00};
    n_sp = 3;
`endif

    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_col", 32'(col), 32'd0);
    chk("rst_pix_wr", 32'(pix_wr), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Pass 1: diagonal image with the table vectors in row 20
    fill_diag();
    for (int k = 0; k < 9; k++) init_img[20][40 + k] = vt[k].pin;
    load_and_model();
    run_pass(1);
    check_image("diag");
    vr = MIR ? 43 : 20;
    for (int k = 0; k < 9; k++) chk("vector", 32'(mem[vr][40 + k]), 32'(vt[k].pexp));
    for (int k = 0; k < n_sp; k++) chk("spot", 32'(mem[sp[k].r][sp[k].c]), 32'(sp[k].pexp));

    // Pass 2: random image, start held through the first 21 busy cycles
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        init_img[i][j] = 24'($urandom());
    load_and_model();
    run_pass(21);
    check_image("random_held_start");

    // Pass 3: reset mid-operation, then a fresh run from (0,0)
    fill_diag();
    load_and_model();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    c = done_cnt;
    repeat (100) @(posedge clk);
    #1;
    for (int k = 0; k < 4 && we !== 1'b1; k++) begin @(posedge clk); #1; end
    chk("abort_we_before", 32'(we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", 32'(we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - c), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    load_and_model();
    run_pass(1);
    check_image("after_abort");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
